rvv_backend_alu_viota_prefix: RTL and testbench
===============================================

RVV_BACKEND_ALU_VIOTA_PREFIX -- requirements
Module: rvv_backend_alu_viota_prefix

Interface
REQ-001 SHALL have parameter VLEN, default `VLEN (128): mask source width in bits.
REQ-002 SHALL have parameter CHUNK, default 16: mask bits counted per cycle; VLEN/CHUNK = 8 passes.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous abort of any operation in flight.
REQ-006 SHALL have port in_valid  input  1  request valid.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid&in_ready at a rising edge.
REQ-008 SHALL have port in_src  input  VLEN  vs2 mask source bits.
REQ-009 SHALL have port in_v0  input  VLEN  v0 mask bits.
REQ-010 SHALL have port in_vm  input  1  1 = unmasked, 0 = masked by v0.
REQ-011 SHALL have port in_vl  input  $clog2(VLEN)+1  element count limit, 0..VLEN.
REQ-012 SHALL have port in_rob_entry  input  `ROB_DEPTH_WIDTH  tag carried to output.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts when out_valid&out_ready at a rising edge.
REQ-015 SHALL have port out_viota_per64  output  [1:0][63:0][$clog2(VLEN)-1:0]  per-64-bit-half inclusive prefix counts feeding the ALU p1 stage data_viota_per64 field.
REQ-016 SHALL have port out_rob_entry  output  `ROB_DEPTH_WIDTH  captured in_rob_entry.

Function
REQ-017 Active bit i SHALL be in_src[i] & (in_vm | in_v0[i]) & (i < in_vl), all operands captured at acceptance.
REQ-018 out_viota_per64[h][j] SHALL equal the count of active bits at indices h*64 .. h*64+j inclusive (range 0..64, 7 bits, no overflow possible).
REQ-019 FSM states SHALL be IDLE, BUSY, DONE.
REQ-020 in_ready SHALL be 1 only in IDLE and flush=0; acceptance moves IDLE->BUSY and clears chunk counter and running accumulator.
REQ-021 In BUSY, each edge SHALL process chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1), write its 16 prefix entries = accumulator + local inclusive prefix, and update accumulator to the chunk's last entry.
REQ-022 Accumulator SHALL be cleared to 0 before chunk 4 (start of half 1); no carry from half 0 into half 1.
REQ-023 Chunk counter SHALL wrap 7->0 and the same edge SHALL move BUSY->DONE.
REQ-024 out_valid SHALL be 1 exactly in DONE; first out_valid cycle is 8 edges after the accepting edge.
REQ-025 out_viota_per64 and out_rob_entry SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 DONE with out_ready=1 SHALL move to IDLE on that edge; no new request is accepted on the same edge (minimum issue interval 10 cycles).
REQ-027 in_src/in_v0/in_vm/in_vl changes after acceptance SHALL NOT affect the result.
REQ-028 flush=1 at an edge SHALL force IDLE and out_valid=0 from any state, overriding acceptance and out handshake on that edge.
REQ-029 in_vl=0 SHALL yield all-zero counts with normal 8-cycle latency.

Reset
REQ-030 rst_n=0 at an edge SHALL force IDLE, out_valid=0, chunk counter=0, accumulator=0, out_viota_per64=0, out_rob_entry=0; in_ready=0 while rst_n=0.
REQ-031 Reset asserted mid-BUSY or in DONE SHALL discard the operation; no out_valid for it after reset release.
REQ-032 in_ready SHALL be 1 in the first cycle after rst_n returns high.

Verification
REQ-033 in_src=all 1, vm=1, vl=128 -> out_valid 8 edges after accept; per64[h][j]=j+1 for both h.
REQ-034 in_src=all 1, vm=0, in_v0=0x5555...5, vl=128 -> per64[h][j]=floor(j/2)+1.
REQ-035 in_src=all 1, vm=1, vl=70 -> per64[0][j]=j+1; per64[1][j]=min(j+1,6).
REQ-036 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-037 flush pulse on 4th BUSY cycle -> out_valid never asserts, in_ready=1 next cycle; repeat with rst_n=0 instead of flush, same result.
REQ-038 vl=0, in_src=all 1 -> all counts 0 after 8 edges, out_rob_entry equals captured tag.

Source files
------------

// File: rtl/rvv_backend_alu_viota_prefix.sv
// viota prefix counter: counts active mask bits CHUNK per cycle and
// produces per-64-bit-half inclusive prefix counts for the ALU p1 stage.
`ifndef VLEN
`define VLEN 128
`endif
`ifndef ROB_DEPTH_WIDTH
`define ROB_DEPTH_WIDTH 5
`endif

module rvv_backend_alu_viota_prefix #(
  parameter int VLEN  = `VLEN,
  parameter int CHUNK = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      flush,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [VLEN-1:0]                           in_src,
  input  logic [VLEN-1:0]                           in_v0,
  input  logic                                      in_vm,
  input  logic [$clog2(VLEN):0]                     in_vl,
  input  logic [`ROB_DEPTH_WIDTH-1:0]               in_rob_entry,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [1:0][63:0][$clog2(VLEN)-1:0]        out_viota_per64,
  output logic [`ROB_DEPTH_WIDTH-1:0]               out_rob_entry
);

  localparam int CW          = $clog2(VLEN);
  localparam int VLW         = $clog2(VLEN) + 1;
  localparam int NCHUNK      = VLEN / CHUNK;
  localparam int KW          = $clog2(NCHUNK);
  localparam int HALF_CHUNKS = 64 / CHUNK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                          state_r;
  state_t                          nxt_s;
  logic [KW-1:0]                   chunk_r;
  logic [CW-1:0]                   acc_r;
  logic [VLEN-1:0]                 act_r;
  logic [VLEN-1:0]                 act_s;
  logic [1:0][63:0][CW-1:0]        viota_r;
  logic [`ROB_DEPTH_WIDTH-1:0]     rob_r;
  logic [CHUNK-1:0]                chunk_bits_s;
  logic [CW-1:0]                   base_s;
  logic [CHUNK-1:0][CW-1:0]        pre_s;
  logic                            accept_s;
  logic                            step_s;

  assign in_ready        = rst_n & ~flush & (state_r == IDLE);
  assign accept_s        = in_valid & in_ready;
  assign step_s          = (state_r == BUSY) & ~flush;
  assign out_valid       = (state_r == DONE);
  assign out_viota_per64 = viota_r;
  assign out_rob_entry   = rob_r;

  // Active-bit vector, frozen into act_r on acceptance.
  always_comb begin
    act_s = '0;
    for (int i = 0; i < VLEN; i++) begin
      act_s[i] = in_src[i] & (in_vm | in_v0[i]) & (VLW'(i) < in_vl);
    end
  end

  // Chunk select and local inclusive prefix; each 64-bit half restarts from zero.
  always_comb begin : prefix_blk
    logic [CW-1:0] run;
    chunk_bits_s = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (chunk_r == KW'(k)) begin
        chunk_bits_s = act_r[k*CHUNK +: CHUNK];
      end else begin
        chunk_bits_s = chunk_bits_s;
      end
    end
    if ((int'(chunk_r) % HALF_CHUNKS) == 0) begin
      base_s = {CW{1'b0}};
    end else begin
      base_s = acc_r;
    end
    run = base_s;
    for (int t = 0; t < CHUNK; t++) begin
      run      = run + CW'(chunk_bits_s[t]);
      pre_s[t] = run;
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) nxt_s = BUSY;
        else          nxt_s = IDLE;
      end
      BUSY: begin
        if (chunk_r == KW'(NCHUNK - 1)) nxt_s = DONE;
        else                            nxt_s = BUSY;
      end
      DONE: begin
        if (out_ready) nxt_s = IDLE;
        else           nxt_s = DONE;
      end
      default: nxt_s = IDLE;
    endcase
    if (flush) begin
      nxt_s = IDLE;
    end else begin
      nxt_s = nxt_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= nxt_s;
    end
  end

  // Operand capture, chunk walk and result storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chunk_r <= {KW{1'b0}};
      acc_r   <= {CW{1'b0}};
      act_r   <= {VLEN{1'b0}};
      viota_r <= '0;
      rob_r   <= {`ROB_DEPTH_WIDTH{1'b0}};
    end else if (accept_s) begin
      chunk_r <= {KW{1'b0}};
      acc_r   <= {CW{1'b0}};
      act_r   <= act_s;
      rob_r   <= in_rob_entry;
    end else if (step_s) begin
      for (int k = 0; k < NCHUNK; k++) begin
        for (int t = 0; t < CHUNK; t++) begin
          if (chunk_r == KW'(k)) begin
            viota_r[(k*CHUNK+t)/64][(k*CHUNK+t)%64] <= pre_s[t];
          end
        end
      end
      acc_r   <= pre_s[CHUNK-1];
      chunk_r <= chunk_r + KW'(1);
    end else begin
      chunk_r <= chunk_r;
    end
  end

endmodule

// File: tb/tb_rvv_backend_alu_viota_prefix.sv
// Scoreboard bench for rvv_backend_alu_viota_prefix: directed vectors,
// expected results queued at issue and checked by an independent monitor.
`ifndef ROB_DEPTH_WIDTH
`define ROB_DEPTH_WIDTH 5
`endif

module tb_rvv_backend_alu_viota_prefix;

  typedef logic [1:0][63:0][6:0] viota_t;
  typedef struct {
    viota_t                      v;
    logic [`ROB_DEPTH_WIDTH-1:0] rob;
    int                          acc_cyc;
  } exp_t;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          flush = 1'b0;
  logic                          in_valid = 1'b0;
  logic                          in_ready;
  logic [127:0]                  in_src = 128'd0;
  logic [127:0]                  in_v0 = 128'd0;
  logic                          in_vm = 1'b1;
  logic [7:0]                    in_vl = 8'd0;
  logic [`ROB_DEPTH_WIDTH-1:0]   in_rob_entry = '0;
  logic                          out_valid;
  logic                          out_ready = 1'b1;
  viota_t                        out_viota_per64;
  logic [`ROB_DEPTH_WIDTH-1:0]   out_rob_entry;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   seen = 1'b0;

  rvv_backend_alu_viota_prefix #(.VLEN(128), .CHUNK(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src(in_src), .in_v0(in_v0), .in_vm(in_vm), .in_vl(in_vl),
    .in_rob_entry(in_rob_entry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_viota_per64(out_viota_per64), .out_rob_entry(out_rob_entry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_viota(input string name, input viota_t act, input viota_t exp);
    int bad = -1;
    for (int i = 0; i < 128; i++)
      if (bad < 0 && act[i/64][i%64] !== exp[i/64][i%64]) bad = i;
    if (bad < 0) bad = 0;
    chk($sformatf("%s[%0d][%0d]", name, bad/64, bad%64),
        act[bad/64][bad%64], exp[bad/64][bad%64]);
  endtask

  function automatic viota_t model(input logic [127:0] src, input logic [127:0] v0,
                                   input logic vm, input int vl);
    viota_t e;
    for (int h = 0; h < 2; h++) begin
      int cnt = 0;
      for (int j = 0; j < 64; j++) begin
        int i = h*64 + j;
        if (src[i] && (vm || v0[i]) && i < vl) cnt++;
        e[h][j] = 7'(cnt);
      end
    end
    return e;
  endfunction

  // Monitor: compares the first out_valid cycle of each result against the queue.
  always @(negedge clk) begin
    if (!rst_n || !out_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      exp_t e;
      seen = 1'b1;
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc - e.acc_cyc, 8);
        chk_viota("viota", out_viota_per64, e.v);
        chk("rob", out_rob_entry, e.rob);
      end
    end
  end

  task automatic issue(input logic [127:0] src, input logic [127:0] v0, input logic vm,
                       input logic [7:0] vl, input logic [`ROB_DEPTH_WIDTH-1:0] rob,
                       input bit push, input viota_t e);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("issue_timeout", 0, 1);
    in_src = src; in_v0 = v0; in_vm = vm; in_vl = vl; in_rob_entry = rob;
    in_valid = 1'b1;
    if (push) q.push_back('{v: e, rob: rob, acc_cyc: cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
    in_src = ~src; in_v0 = ~v0; in_vm = ~vm; in_vl = 8'd37; in_rob_entry = ~rob;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("wait_out_valid_timeout", 0, 1);
  endtask

  viota_t e_ones, e_half, e_vl70, e_zero, e_mix;
  logic [127:0] ones = {128{1'b1}};
  logic [127:0] alt  = {32{4'h5}};
  logic [127:0] pat_src = 128'hF0F0_1234_DEAD_BEEF_0F0F_A5A5_8001_7FFE;
  logic [127:0] pat_v0  = 128'h3333_FFFF_0000_C3C3_5A5A_1111_FFFF_0F0F;

  initial begin
    int nv;
    for (int h = 0; h < 2; h++)
      for (int j = 0; j < 64; j++) begin
        e_ones[h][j] = 7'(j + 1);
        e_half[h][j] = 7'(j/2 + 1);
        e_vl70[h][j] = (h == 0) ? 7'(j + 1) : 7'((j + 1 < 6) ? j + 1 : 6);
        e_zero[h][j] = 7'd0;
      end
    e_mix = model(pat_src, pat_v0, 1'b0, 100);

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk_viota("rst_viota", out_viota_per64, e_zero);
    chk("rst_rob", out_rob_entry, 0);
    rst_n = 1'b1;
    #1 chk("in_ready_after_rst", in_ready, 1);

    issue(ones, 128'd0, 1'b1, 8'd128, 5'd3, 1'b1, e_ones);
    issue(ones, alt, 1'b0, 8'd128, 5'd9, 1'b1, e_half);
    issue(ones, 128'd0, 1'b1, 8'd70, 5'd17, 1'b1, e_vl70);
    issue(ones, 128'd0, 1'b1, 8'd0, 5'h1b, 1'b1, e_zero);
    issue(pat_src, pat_v0, 1'b0, 8'd100, 5'd22, 1'b1, e_mix);

    // Backpressure: results must hold for 5 stalled cycles.
    wait_valid();
    @(negedge clk);
    out_ready = 1'b0;
    issue(ones, alt, 1'b0, 8'd128, 5'd30, 1'b1, e_half);
    wait_valid();
    in_valid = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_stable", out_viota_per64 == e_half, 1);
      chk("stall_rob", out_rob_entry, 30);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);

    // Flush during the 4th BUSY cycle.
    issue(ones, 128'd0, 1'b1, 8'd128, 5'd5, 1'b0, e_ones);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("post_flush_in_ready", in_ready, 1);
    nv = 0;
    repeat (12) @(negedge clk) if (out_valid) nv++;
    chk("flush_no_valid", nv, 0);

    // Reset during the 4th BUSY cycle.
    issue(ones, 128'd0, 1'b1, 8'd128, 5'd6, 1'b0, e_ones);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_mid_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_rob", out_rob_entry, 0);
    nv = 0;
    repeat (12) @(negedge clk) if (out_valid) nv++;
    chk("rst_no_valid", nv, 0);

    issue(ones, 128'd0, 1'b1, 8'd70, 5'd11, 1'b1, e_vl70);
    wait_valid();
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
